// File: rtl/branch_resolve.sv
// Branch resolution for the EX stage: keeps the architectural {Z,V,N} flag
// register, evaluates conditional branches, issues a registered redirect to
// fetch and sequences a fixed-length flush of the younger IF/ID stages.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | normal operation; flags update and branches are evaluated
// FLUSH | wrong-path window after a taken branch; br_valid/flag_we ignored
module branch_resolve #(
  parameter int ASIZE        = 16,
  parameter int OSIZE        = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flag_we,
  input  logic [2:0]       alu_flag,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  input  logic [ASIZE-1:0] br_pc,
  input  logic [OSIZE-1:0] br_off,
  output logic [2:0]       flags_q,
  output logic             redirect,
  output logic [ASIZE-1:0] redirect_pc,
  output logic             flush,
  output logic [15:0]      br_total,
  output logic [15:0]      br_taken
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  // The redirect cycle itself is the first flush cycle, so the counter only
  // has to cover the remaining FLUSH_CYCLES-1 cycles.
  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       flags_d;
  logic             redirect_d;
  logic [ASIZE-1:0] redirect_pc_d;
  logic             flush_d;
  logic [15:0]      br_total_d, br_taken_d;

  logic [2:0]       eff_flag;
  logic             flag_z, flag_v, flag_n;
  logic             cond_true;
  logic [ASIZE-1:0] target;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Newest ALU result bypasses the flag register for same-cycle branches.
  always_comb begin
    eff_flag = flag_we ? alu_flag : flags_q;
    flag_z   = eff_flag[2];
    flag_v   = eff_flag[1];
    flag_n   = eff_flag[0];
    target   = br_pc + ASIZE'(1) + ASIZE'($signed(br_off));
  end

  // Condition code decode against the effective flags.
  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = !flag_z;
      3'b011:  cond_true = flag_n;
      3'b100:  cond_true = !flag_n;
      3'b101:  cond_true = flag_v;
      3'b110:  cond_true = !flag_v;
      default: cond_true = 1'b0;
    endcase
  end

  // Next-state and next-output logic; everything defaults to hold.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flags_d       = flags_q;
    redirect_d    = redirect;
    redirect_pc_d = redirect_pc;
    flush_d       = flush;
    br_total_d    = br_total;
    br_taken_d    = br_taken;
    case (state_q)
      IDLE: begin
        redirect_d = 1'b0;
        flush_d    = 1'b0;
        if (flag_we) flags_d = alu_flag;
        if (br_valid) begin
          br_total_d = sat_inc(br_total);
          if (cond_true) begin
            br_taken_d    = sat_inc(br_taken);
            redirect_d    = 1'b1;
            redirect_pc_d = target;
            flush_d       = 1'b1;
            cnt_d         = CNT_LOAD;
            if (FLUSH_CYCLES > 1) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        redirect_d = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          flush_d = 1'b0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          flush_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; a stall freezes every one of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      flags_q     <= 3'b000;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      flush       <= 1'b0;
      br_total    <= 16'd0;
      br_taken    <= 16'd0;
    end else if (!stall) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      redirect    <= redirect_d;
      redirect_pc <= redirect_pc_d;
      flush       <= flush_d;
      br_total    <= br_total_d;
      br_taken    <= br_taken_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: one instance with the default two-cycle
// flush and a second with FLUSH_CYCLES=1 for back-to-back and saturation.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n, rst1_n;
  logic        stall, flag_we, br_valid;
  logic [2:0]  alu_flag, br_cond;
  logic [15:0] br_pc;
  logic [7:0]  br_off;

  logic [2:0]  flags_q, flags1;
  logic        redirect, flush, redirect1, flush1;
  logic [15:0] redirect_pc, br_total, br_taken;
  logic [15:0] redirect_pc1, br_total1, br_taken1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve #(.ASIZE(16), .OSIZE(8), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flag_we(flag_we),
    .alu_flag(alu_flag), .br_valid(br_valid), .br_cond(br_cond),
    .br_pc(br_pc), .br_off(br_off), .flags_q(flags_q),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .br_total(br_total), .br_taken(br_taken)
  );

  branch_resolve #(.ASIZE(16), .OSIZE(8), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .stall(stall), .flag_we(flag_we),
    .alu_flag(alu_flag), .br_valid(br_valid), .br_cond(br_cond),
    .br_pc(br_pc), .br_off(br_off), .flags_q(flags1),
    .redirect(redirect1), .redirect_pc(redirect_pc1), .flush(flush1),
    .br_total(br_total1), .br_taken(br_taken1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flag_we = 0; alu_flag = 3'b000; br_valid = 0;
    br_cond = 3'b111; br_pc = 16'h0000; br_off = 8'h00;
  endtask

  task automatic branch(input logic [2:0] c, input logic [15:0] pc, input logic [7:0] off);
    br_valid = 1; br_cond = c; br_pc = pc; br_off = off;
  endtask

  initial begin
    rst_n = 0; rst1_n = 0;
    idle_inputs();

    // reset with random inputs toggling
    repeat (4) begin
      step();
      stall = 1'($urandom); flag_we = 1'($urandom); alu_flag = 3'($urandom);
      br_valid = 1'($urandom); br_cond = 3'($urandom);
      br_pc = 16'($urandom); br_off = 8'($urandom);
    end
    chk("rst_flags", 32'(flags_q), 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_redirect_pc", 32'(redirect_pc), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_total", 32'(br_total), 32'h0);
    chk("rst_taken", 32'(br_taken), 32'h0);

    rst_n = 1;
    idle_inputs();
    flag_we = 1; alu_flag = 3'b100;
    step();
    chk("first_flag_write", 32'(flags_q), 32'h4);

    // taken branch on Z: 0x0010 + 1 - 4 = 0x000D
    idle_inputs();
    branch(3'b001, 16'h0010, 8'hFC);
    step();
    chk("taken_redirect", 32'(redirect), 32'h1);
    chk("taken_pc", 32'(redirect_pc), 32'h000D);
    chk("taken_flush0", 32'(flush), 32'h1);
    chk("taken_total", 32'(br_total), 32'h1);
    chk("taken_taken", 32'(br_taken), 32'h1);
    idle_inputs();
    step();
    chk("taken_redirect_drop", 32'(redirect), 32'h0);
    chk("taken_flush1", 32'(flush), 32'h1);
    step();
    chk("taken_flush_end", 32'(flush), 32'h0);
    chk("taken_pc_hold", 32'(redirect_pc), 32'h000D);

    // bypass: same-cycle N=1 drives cond 011; target wraps 0xFFFF+1+1 = 0x0001
    flag_we = 1; alu_flag = 3'b001;
    branch(3'b011, 16'hFFFF, 8'h01);
    step();
    chk("bypass_redirect", 32'(redirect), 32'h1);
    chk("bypass_wrap_pc", 32'(redirect_pc), 32'h0001);
    chk("bypass_flags", 32'(flags_q), 32'h1);
    chk("bypass_taken", 32'(br_taken), 32'h2);
    idle_inputs();
    step();
    step();
    chk("bypass_flush_end", 32'(flush), 32'h0);

    // not taken: !Z with Z set
    flag_we = 1; alu_flag = 3'b100;
    step();
    idle_inputs();
    branch(3'b010, 16'h0040, 8'h10);
    step();
    chk("nt_redirect", 32'(redirect), 32'h0);
    chk("nt_flush", 32'(flush), 32'h0);
    chk("nt_total", 32'(br_total), 32'h3);
    chk("nt_taken", 32'(br_taken), 32'h2);

    // taken, then wrong-path branch and flag write during FLUSH
    branch(3'b000, 16'h0020, 8'h00);
    step();
    chk("wp_redirect", 32'(redirect), 32'h1);
    chk("wp_pc", 32'(redirect_pc), 32'h0021);
    branch(3'b000, 16'h0500, 8'h05);
    flag_we = 1; alu_flag = 3'b010;
    step();
    chk("wp_no_redirect", 32'(redirect), 32'h0);
    chk("wp_flush", 32'(flush), 32'h1);
    chk("wp_total", 32'(br_total), 32'h4);
    chk("wp_taken", 32'(br_taken), 32'h3);
    chk("wp_flags", 32'(flags_q), 32'h4);
    chk("wp_pc_hold", 32'(redirect_pc), 32'h0021);
    idle_inputs();
    step();
    chk("wp_flush_end", 32'(flush), 32'h0);

    // stall during redirect: 0x0100 + 1 - 128 = 0x0081
    branch(3'b000, 16'h0100, 8'h80);
    step();
    chk("st_redirect", 32'(redirect), 32'h1);
    chk("st_pc", 32'(redirect_pc), 32'h0081);
    stall = 1;
    branch(3'b000, 16'h0200, 8'h00);
    flag_we = 1; alu_flag = 3'b011;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_hold_redirect", 32'(redirect), 32'h1);
      chk("st_hold_flush", 32'(flush), 32'h1);
    end
    chk("st_hold_total", 32'(br_total), 32'h5);
    chk("st_hold_flags", 32'(flags_q), 32'h4);
    idle_inputs();
    step();
    chk("st_redirect_drop", 32'(redirect), 32'h0);
    chk("st_flush1", 32'(flush), 32'h1);
    step();
    chk("st_flush_end", 32'(flush), 32'h0);
    chk("st_taken", 32'(br_taken), 32'h4);

    // reset mid-flush
    branch(3'b000, 16'h0300, 8'h00);
    step();
    chk("rmf_flush_before", 32'(flush), 32'h1);
    idle_inputs();
    #2 rst_n = 0;
    #1;
    chk("rmf_flush", 32'(flush), 32'h0);
    chk("rmf_redirect", 32'(redirect), 32'h0);
    chk("rmf_total", 32'(br_total), 32'h0);
    #1 rst_n = 1;

    // FLUSH_CYCLES=1: back-to-back redirects and counter saturation
    @(negedge clk);
    rst1_n = 1;
    step();
    branch(3'b000, 16'h1000, 8'h02);
    for (int i = 1; i <= 65537; i++) begin
      step();
      chk("b2b_redirect", 32'(redirect1), 32'h1);
      chk("b2b_flush", 32'(flush1), 32'h1);
      if (i == 100) chk("sat_total_mid", 32'(br_total1), 32'd100);
      if (i == 65535) chk("sat_total_reach", 32'(br_total1), 32'hFFFF);
    end
    chk("b2b_pc", 32'(redirect_pc1), 32'h1003);
    chk("sat_total", 32'(br_total1), 32'hFFFF);
    chk("sat_taken", 32'(br_taken1), 32'hFFFF);
    idle_inputs();
    step();
    chk("b2b_redirect_end", 32'(redirect1), 32'h0);
    chk("b2b_flush_end", 32'(flush1), 32'h0);
    chk("sat_total_hold", 32'(br_total1), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
